// File: rtl/aes_pkg.sv
// Shared constants, FSM encoding and job payload for the AES job arbiter.
package aes_pkg;

  localparam int unsigned AES_BLOCK_W     = 128;
  localparam int unsigned DEFAULT_TIMEOUT = 1023;
  localparam int unsigned JOB_CNT_W       = 16;

  typedef logic [AES_BLOCK_W-1:0] block_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // One accepted job: operands plus the requester that owns the result.
  typedef struct packed {
    block_t pt;
    block_t key;
    logic   owner;
  } job_t;

endpackage

// File: rtl/aes_job_arbiter_if.sv
// Requester, response and AES-core handshake signals of the job arbiter.
interface aes_job_arbiter_if;
  import aes_pkg::*;

  logic   req0_valid;
  logic   req0_ready;
  block_t req0_pt;
  block_t req0_key;
  logic   req1_valid;
  logic   req1_ready;
  block_t req1_pt;
  block_t req1_key;

  logic   rsp0_valid;
  logic   rsp0_ready;
  block_t rsp0_ct;
  logic   rsp0_err;
  logic   rsp1_valid;
  logic   rsp1_ready;
  block_t rsp1_ct;
  logic   rsp1_err;

  logic   core_start;
  logic   core_abort;
  block_t core_pt;
  block_t core_key;
  logic   core_done;
  block_t core_ct;

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_pt, req0_key, req1_valid, req1_pt, req1_key,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_ct, rsp0_err, rsp1_valid, rsp1_ct, rsp1_err,
    input  rsp0_ready, rsp1_ready,
    output core_start, core_abort, core_pt, core_key,
    input  core_done, core_ct
  );

  // Requesters and core side.
  modport master (
    output req0_valid, req0_pt, req0_key, req1_valid, req1_pt, req1_key,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_ct, rsp0_err, rsp1_valid, rsp1_ct, rsp1_err,
    output rsp0_ready, rsp1_ready,
    input  core_start, core_abort, core_pt, core_key,
    output core_done, core_ct
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; the history bit only moves on an accepted grant.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant_c
);

  logic last_grant;

  // Single requester always wins; a tie goes to the one not granted last.
  always_comb begin
    grant_c = 2'b00;
    case (req)
      2'b01:   grant_c = 2'b01;
      2'b10:   grant_c = 2'b10;
      2'b11:   grant_c = last_grant ? 2'b01 : 2'b10;
      default: grant_c = 2'b00;
    endcase
  end

  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (accept && (grant_c != 2'b00)) begin
      last_grant <= grant_c[1];
    end
  end

endmodule

// File: rtl/aes_job_arbiter.sv
// Accepts AES jobs from two requesters, runs them one at a time on a shared
// core with a completion timeout, and returns the result to the owner.
module aes_job_arbiter
  import aes_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  aes_job_arbiter_if.slave     bus,
  output logic                 busy,
  output logic [JOB_CNT_W-1:0] job_count
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t           state;
  job_t             job;
  logic [CNT_W-1:0] cnt;
  logic             core_start;
  logic             core_abort;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_err;
  block_t           rsp_ct [2];
  logic [1:0]       req;
  logic [1:0]       grant_c;
  logic             accept;
  logic             terminal;
  logic             rsp_taken;

  // Requests are only visible to the arbiter while idle and out of reset.
  assign req    = {bus.req1_valid, bus.req0_valid} & {2{(state == ST_IDLE) && !rst}};
  assign accept = (grant_c != 2'b00);

  rr_arbiter2 u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .accept  (accept),
    .grant_c (grant_c)
  );

  assign terminal  = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign rsp_taken = job.owner ? (rsp_valid[1] && bus.rsp1_ready)
                               : (rsp_valid[0] && bus.rsp0_ready);

  assign bus.req0_ready = grant_c[0];
  assign bus.req1_ready = grant_c[1];
  assign bus.rsp0_valid = rsp_valid[0];
  assign bus.rsp1_valid = rsp_valid[1];
  assign bus.rsp0_err   = rsp_err[0];
  assign bus.rsp1_err   = rsp_err[1];
  assign bus.rsp0_ct    = rsp_ct[0];
  assign bus.rsp1_ct    = rsp_ct[1];
  assign bus.core_start = core_start;
  assign bus.core_abort = core_abort;
  assign bus.core_pt    = job.pt;
  assign bus.core_key   = job.key;

  // Job FSM: accept, launch, wait for core or timeout, hold response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      job        <= '0;
      cnt        <= '0;
      core_start <= 1'b0;
      core_abort <= 1'b0;
      rsp_valid  <= 2'b00;
      rsp_err    <= 2'b00;
      rsp_ct[0]  <= '0;
      rsp_ct[1]  <= '0;
      busy       <= 1'b0;
      job_count  <= '0;
    end else begin
      core_start <= 1'b0;
      core_abort <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            job.owner  <= grant_c[1];
            job.pt     <= grant_c[1] ? bus.req1_pt  : bus.req0_pt;
            job.key    <= grant_c[1] ? bus.req1_key : bus.req0_key;
            core_start <= 1'b1;
            busy       <= 1'b1;
            state      <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          cnt   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // Completion takes priority over a timeout in the same cycle.
          if (bus.core_done) begin
            rsp_ct[job.owner]    <= bus.core_ct;
            rsp_err[job.owner]   <= 1'b0;
            rsp_valid[job.owner] <= 1'b1;
            job_count            <= job_count + JOB_CNT_W'(1);
            state                <= ST_RESP;
          end else if (terminal) begin
            core_abort           <= 1'b1;
            rsp_ct[job.owner]    <= '0;
            rsp_err[job.owner]   <= 1'b1;
            rsp_valid[job.owner] <= 1'b1;
            state                <= ST_RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (rsp_taken) begin
            rsp_valid <= 2'b00;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_job_arbiter.sv
// Self-checking bench: a short-timeout instance for most traffic and a
// default-timeout instance for the long-latency known-answer job.
module tb_aes_job_arbiter;

  localparam logic [127:0] VEC_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] VEC_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] VEC_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b1;
  logic v0 = 1'b0, v1 = 1'b0;
  logic [1:0] rr = 2'b00;
  logic [127:0] pt0 = '0, key0 = '0, pt1 = '0, key1 = '0;
  logic cdone = 1'b0;
  logic [127:0] cct = '0;

  int n_cmp = 0;
  int n_err = 0;
  int last_m [2];
  int cnt_m [2];

  always #5 clk = ~clk;

  aes_job_arbiter_if ia ();
  aes_job_arbiter_if ib ();
  logic        busy_a, busy_b;
  logic [15:0] cnt_a, cnt_b;

  aes_job_arbiter #(.TIMEOUT_CYCLES(16)) dut_a (
    .clk(clk), .rst(rst), .bus(ia), .busy(busy_a), .job_count(cnt_a));
  aes_job_arbiter dut_b (
    .clk(clk), .rst(rst), .bus(ib), .busy(busy_b), .job_count(cnt_b));

  assign ia.req0_valid = v0 & ~sel;
  assign ia.req1_valid = v1 & ~sel;
  assign ib.req0_valid = v0 & sel;
  assign ib.req1_valid = v1 & sel;
  assign ia.req0_pt = pt0;  assign ib.req0_pt = pt0;
  assign ia.req1_pt = pt1;  assign ib.req1_pt = pt1;
  assign ia.req0_key = key0; assign ib.req0_key = key0;
  assign ia.req1_key = key1; assign ib.req1_key = key1;
  assign ia.rsp0_ready = rr[0] & ~sel;
  assign ia.rsp1_ready = rr[1] & ~sel;
  assign ib.rsp0_ready = rr[0] & sel;
  assign ib.rsp1_ready = rr[1] & sel;
  assign ia.core_done = cdone & ~sel;
  assign ib.core_done = cdone & sel;
  assign ia.core_ct = cct;
  assign ib.core_ct = cct;

  logic [1:0]   o_ready, o_rvalid, o_err;
  logic [127:0] o_ct0, o_ct1, o_cpt, o_ckey;
  logic         o_start, o_abort, o_busy;
  logic [15:0]  o_cnt;

  assign o_ready  = sel ? {ib.req1_ready, ib.req0_ready} : {ia.req1_ready, ia.req0_ready};
  assign o_rvalid = sel ? {ib.rsp1_valid, ib.rsp0_valid} : {ia.rsp1_valid, ia.rsp0_valid};
  assign o_err    = sel ? {ib.rsp1_err, ib.rsp0_err}     : {ia.rsp1_err, ia.rsp0_err};
  assign o_ct0    = sel ? ib.rsp0_ct : ia.rsp0_ct;
  assign o_ct1    = sel ? ib.rsp1_ct : ia.rsp1_ct;
  assign o_cpt    = sel ? ib.core_pt : ia.core_pt;
  assign o_ckey   = sel ? ib.core_key : ia.core_key;
  assign o_start  = sel ? ib.core_start : ia.core_start;
  assign o_abort  = sel ? ib.core_abort : ia.core_abort;
  assign o_busy   = sel ? busy_b : busy_a;
  assign o_cnt    = sel ? cnt_b : cnt_a;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 128'(o_ready), 0);
    chk({tag, "_rvalid"}, 128'(o_rvalid), 0);
    chk({tag, "_err"}, 128'(o_err), 0);
    chk({tag, "_ct0"}, o_ct0, 0);
    chk({tag, "_ct1"}, o_ct1, 0);
    chk({tag, "_start"}, 128'(o_start), 0);
    chk({tag, "_abort"}, 128'(o_abort), 0);
    chk({tag, "_cpt"}, o_cpt, 0);
    chk({tag, "_ckey"}, o_ckey, 0);
    chk({tag, "_busy"}, 128'(o_busy), 0);
    chk({tag, "_cnt"}, 128'(o_cnt), 0);
  endtask

  // One complete job: request, launch, core model with latency lat
  // (0 = never done), response held for hold cycles, then consumed.
  task automatic job(input bit a0, input bit a1, input int lat, input int hold, input bit vec);
    int g, tmo, s;
    bit tout;
    logic [127:0] ept, ekey, ect, rct;
    s   = sel ? 1 : 0;
    tmo = sel ? 1023 : 16;
    @(negedge clk);
    pt0 = rnd128(); key0 = rnd128(); pt1 = rnd128(); key1 = rnd128();
    if (vec) begin pt0 = VEC_PT; key0 = VEC_KEY; end
    v0 = a0; v1 = a1;
    g = (a0 && a1) ? 1 - last_m[s] : (a0 ? 0 : 1);
    ept  = g ? pt1 : pt0;
    ekey = g ? key1 : key0;
    ect  = vec ? VEC_CT : (ept ^ {ekey[63:0], ekey[127:64]} ^ 128'(g + 1));
    #1;
    chk("grant0", 128'(o_ready[0]), 128'(g == 0));
    chk("grant1", 128'(o_ready[1]), 128'(g == 1));
    chk("idle_busy", 128'(o_busy), 0);
    @(posedge clk);
    last_m[s] = g;
    @(negedge clk);
    if (g == 0) v0 = 1'b0; else v1 = 1'b0;
    chk("launch_start", 128'(o_start), 1);
    chk("launch_pt", o_cpt, ept);
    chk("launch_key", o_ckey, ekey);
    chk("launch_busy", 128'(o_busy), 1);
    chk("launch_ready", 128'(o_ready), 0);
    tout = 1'b0;
    for (int c = 1; c <= tmo; c++) begin
      @(negedge clk);
      chk("wait_start", 128'(o_start), 0);
      chk("wait_abort", 128'(o_abort), 0);
      chk("wait_rvalid", 128'(o_rvalid), 0);
      chk("wait_ready", 128'(o_ready), 0);
      chk("wait_pt", o_cpt, ept);
      cdone = (c == lat);
      cct   = (c == lat) ? ect : rnd128();
      if (c == lat) break;
      if (c == tmo) begin tout = 1'b1; break; end
    end
    @(negedge clk);
    cdone = 1'b0;
    if (!tout) cnt_m[s] = (cnt_m[s] + 1) % 65536;
    rct = tout ? 128'h0 : ect;
    chk("rsp_valid", 128'(o_rvalid), g ? 128'h2 : 128'h1);
    chk("rsp_err", 128'(g ? o_err[1] : o_err[0]), 128'(tout));
    chk("rsp_ct", g ? o_ct1 : o_ct0, rct);
    chk("rsp_abort", 128'(o_abort), 128'(tout));
    chk("rsp_cnt", 128'(o_cnt), 128'(cnt_m[s]));
    chk("rsp_busy", 128'(o_busy), 1);
    for (int h = 0; h < hold; h++) begin
      cdone = (h == 0);
      cct   = rnd128();
      @(negedge clk);
      cdone = 1'b0;
      chk("hold_valid", 128'(o_rvalid), g ? 128'h2 : 128'h1);
      chk("hold_ct", g ? o_ct1 : o_ct0, rct);
      chk("hold_err", 128'(g ? o_err[1] : o_err[0]), 128'(tout));
      chk("hold_abort", 128'(o_abort), 0);
      chk("hold_ready", 128'(o_ready), 0);
      chk("hold_cnt", 128'(o_cnt), 128'(cnt_m[s]));
      chk("hold_pt", o_cpt, ept);
    end
    rr[g] = 1'b1;
    @(negedge clk);
    rr = 2'b00;
    v0 = 1'b0; v1 = 1'b0;
    chk("done_rvalid", 128'(o_rvalid), 0);
    chk("done_busy", 128'(o_busy), 0);
    chk("done_abort", 128'(o_abort), 0);
  endtask

  initial begin
    int ra0, ra1;
    last_m[0] = 1; last_m[1] = 1;
    cnt_m[0] = 0;  cnt_m[1] = 0;
    repeat (2) @(negedge clk);
    chk_all_zero("rst_b");
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("post_rst_b");

    // Known-answer job on the default-timeout instance, 50-cycle core.
    job(1'b1, 1'b0, 50, 2, 1'b1);

    sel = 1'b0;
    @(negedge clk);
    chk_all_zero("post_rst_a");

    // Contention: alternating grants, last response back-pressured.
    job(1'b1, 1'b1, $urandom_range(1, 10), 1, 1'b0);
    job(1'b1, 1'b1, $urandom_range(1, 10), 0, 1'b0);
    job(1'b1, 1'b1, $urandom_range(1, 10), 2, 1'b0);
    job(1'b1, 1'b1, $urandom_range(1, 10), 20, 1'b0);

    // Timeout, then completion on the terminal-count cycle.
    job(1'b0, 1'b1, 0, 3, 1'b0);
    job(1'b1, 1'b1, 16, 1, 1'b0);
    job(1'b1, 1'b0, 15, 1, 1'b0);

    // Random traffic; latencies past 16 exercise the timeout path.
    for (int i = 0; i < 30; i++) begin
      ra0 = int'($urandom_range(0, 1));
      ra1 = ra0 != 0 ? int'($urandom_range(0, 1)) : 1;
      job(ra0 != 0, ra1 != 0, int'($urandom_range(1, 20)), int'($urandom_range(0, 4)), 1'b0);
    end

    // Reset during WAIT with both requesters still presenting jobs.
    @(negedge clk);
    v0 = 1'b1; v1 = 1'b1;
    pt0 = rnd128(); pt1 = rnd128();
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_all_zero("mid_rst");
    @(negedge clk);
    chk_all_zero("mid_rst_hold");
    v0 = 1'b0; v1 = 1'b0;
    rst = 1'b0;
    last_m[0] = 1; last_m[1] = 1;
    cnt_m[0] = 0;  cnt_m[1] = 0;
    @(negedge clk);
    chk_all_zero("after_rst");
    job(1'b1, 1'b1, 5, 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/aes_job_arbiter.md
AES_JOB_ARBITER -- requirements
Module: aes_job_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1023, giving the maximum cycles in WAIT before a job is aborted.
REQ-002 SHALL have port clk, input, 1 bit: the clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have reqN_valid (N=0,1), input, 1 bit: requester N presents a job.
REQ-005 SHALL have reqN_ready, output, 1 bit: job from requester N accepted this cycle.
REQ-006 SHALL have reqN_pt, input, 128 bits: plaintext block of requester N.
REQ-007 SHALL have reqN_key, input, 128 bits: cipher key of requester N.
REQ-008 SHALL have rspN_valid, output, 1 bit: result available for requester N.
REQ-009 SHALL have rspN_ready, input, 1 bit: requester N consumes the result.
REQ-010 SHALL have rspN_ct, output, 128 bits: ciphertext returned to requester N.
REQ-011 SHALL have rspN_err, output, 1 bit: job N timed out; rspN_ct is invalid.
REQ-012 SHALL have core_start, output, 1 bit: single-cycle launch pulse to the AES core.
REQ-013 SHALL have core_abort, output, 1 bit: single-cycle pulse that forces the core back to idle.
REQ-014 SHALL have core_pt and core_key, outputs, 128 bits each: operands driven to the core.
REQ-015 SHALL have core_done, input, 1 bit: the core finished its 10 rounds.
REQ-016 SHALL have core_ct, input, 128 bits: core result, valid while core_done=1.
REQ-017 SHALL have busy, output, 1 bit: the FSM is not in IDLE.
REQ-018 SHALL have job_count, output, 16 bits: count of successfully completed jobs.

Function
REQ-019 SHALL implement FSM states IDLE, LAUNCH, WAIT, RESP.
REQ-020 IDLE: reqN_ready SHALL be asserted combinationally for the granted valid requester only; a handshake (valid&ready) captures pt, key and owner ID, then moves to LAUNCH.
REQ-021 With both requesters valid, the grant SHALL go to the requester not granted last; after reset, requester 0 wins first.
REQ-022 When a single requester is valid, that requester SHALL be granted regardless of history; last_grant updates only on a handshake.
REQ-023 LAUNCH: core_start SHALL be high for exactly one cycle (the cycle after acceptance), the cycle counter SHALL clear, and the FSM then moves to WAIT.
REQ-024 core_pt and core_key SHALL be held stable from LAUNCH until the FSM returns to IDLE.
REQ-025 WAIT: core_done SHALL be sampled only in WAIT (ignored in other states); on core_done, core_ct is captured, err=0, job_count increments (wrapping 0xFFFF to 0x0000), and the FSM moves to RESP.
REQ-026 WAIT: the counter increments each cycle; when it reaches TIMEOUT_CYCLES without core_done, core_abort pulses for one cycle, ct=0, err=1, and the FSM moves to RESP.
REQ-027 If core_done and the timeout terminal count occur in the same cycle, completion SHALL win (err=0, no abort).
REQ-028 RESP: only the owner's rspN_valid SHALL be high, with ct and err stable until rspN_ready; on that handshake the FSM returns to IDLE.
REQ-029 No new request SHALL be accepted outside IDLE; both reqN_ready are 0 in LAUNCH, WAIT and RESP.
REQ-030 Minimum accept-to-rsp_valid latency SHALL be 3 cycles plus core latency.

Reset
REQ-031 On rst: state=IDLE, last_grant=1, counter=0, job_count=0, and all outputs (ready, valid, ct, err, core_start, core_abort, core_pt, core_key, busy) SHALL be 0.
REQ-032 Reset mid-job SHALL discard the held job with no response and no core_abort pulse.

Structure
REQ-033 A shared package aes_pkg SHALL hold the FSM state encoding, AES_BLOCK_W=128 and the default timeout constant.
REQ-034 Grant logic SHALL be a sub-module rr_arbiter2 (two-way round-robin, last_grant register inside it).

Verification
REQ-035 Single job: req0 pt=0x00112233445566778899aabbccddeeff, key=0x000102030405060708090a0b0c0d0e0f; model core returns 0x69c4e0d86a7b0430d8cdb78070b4c55a after 50 cycles -> rsp0_valid, rsp0_ct=that value, err=0, job_count=1.
REQ-036 Both valid for 4 consecutive jobs -> grant order 0,1,0,1; each response goes only to its owner.
REQ-037 Core never asserts done, TIMEOUT_CYCLES=16 -> core_abort pulses once 16 cycles into WAIT; rsp_err=1, rsp_ct=0, job_count unchanged.
REQ-038 core_done on the timeout terminal-count cycle -> err=0, no abort, ct captured.
REQ-039 rsp1_ready held low 20 cycles -> rsp1_valid and ct stable; req0 remains un-readied throughout.
REQ-040 rst asserted during WAIT -> all outputs 0 immediately; the next job is granted to requester 0.
